// File: rtl/dmem_mmio_responder.sv
// Data-side responder for the CPU MEM stage: word RAM, LED/switch MMIO window and a
// prescaled compare timer with a level interrupt. Reads are combinational, writes on clk.
module dmem_mmio_responder #(
    parameter int unsigned RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int unsigned PRESCALE  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        irq
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

    localparam logic [7:0] OffLed     = 8'h00;
    localparam logic [7:0] OffSw      = 8'h04;
    localparam logic [7:0] OffCount   = 8'h08;
    localparam logic [7:0] OffCompare = 8'h0C;
    localparam logic [7:0] OffCtrl    = 8'h10;
    localparam logic [7:0] OffStatus  = 8'h14;

    logic [31:0]       mem_q [2**RAM_AW];
    logic [15:0]       led_q, led_d;
    logic [15:0]       sw_s1_q, sw_s2_q;
    logic [31:0]       count_q, count_d;
    logic [31:0]       compare_q, compare_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              match_q, match_d;
    logic [PreW-1:0]   pre_q, pre_d;

    logic              ram_sel, mmio_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [7:0]        offset;
    logic              we_ram, we_led, we_count, we_compare, we_ctrl, we_status;
    logic              tick, hit;
    logic              unused_addr;

    assign unused_addr = ^addr[1:0];

    assign ram_sel  = (addr[31:RAM_AW+2] == '0);
    assign mmio_sel = (addr[31:16] == MMIO_BASE[31:16]);
    assign ram_idx  = addr[RAM_AW+1:2];
    assign offset   = addr[7:0];

    always_comb begin
        we_ram     = MemWrite && ram_sel;
        we_led     = MemWrite && mmio_sel && (offset == OffLed);
        we_count   = MemWrite && mmio_sel && (offset == OffCount);
        we_compare = MemWrite && mmio_sel && (offset == OffCompare);
        we_ctrl    = MemWrite && mmio_sel && (offset == OffCtrl);
        we_status  = MemWrite && mmio_sel && (offset == OffStatus);
    end

    assign tick = ctrl_q[0] && (pre_q == PreMax);
    assign hit  = tick && (count_q == compare_q);

    always_comb begin
        led_d     = we_led ? writedata[15:0] : led_q;
        compare_d = we_compare ? writedata : compare_q;
        ctrl_d    = we_ctrl ? writedata[2:0] : ctrl_q;

        // CPU store to COUNT overrides whatever the tick would have done.
        count_d = count_q;
        if (we_count) begin
            count_d = writedata;
        end else if (tick) begin
            count_d = (hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
        end

        // Match set beats a same-cycle write-1-to-clear.
        match_d = match_q;
        if (hit) begin
            match_d = 1'b1;
        end else if (we_status && writedata[0]) begin
            match_d = 1'b0;
        end

        // Prescaler parks at 0 whenever enable is (or is about to be) low.
        if (!ctrl_q[0] || !ctrl_d[0] || tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q     <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ctrl_q    <= '0;
            match_q   <= 1'b0;
            pre_q     <= '0;
        end else begin
            led_q     <= led_d;
            sw_s1_q   <= sw;
            sw_s2_q   <= sw_s1_q;
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
            match_q   <= match_d;
            pre_q     <= pre_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (we_ram) begin
            mem_q[ram_idx] <= writedata;
        end
    end

    always_comb begin
        readdata = 32'd0;
        if (ram_sel) begin
            readdata = mem_q[ram_idx];
        end else if (mmio_sel) begin
            case (offset)
                OffLed:     readdata = {16'd0, led_q};
                OffSw:      readdata = {16'd0, sw_s2_q};
                OffCount:   readdata = count_q;
                OffCompare: readdata = compare_q;
                OffCtrl:    readdata = {29'd0, ctrl_q};
                OffStatus:  readdata = {31'd0, match_q};
                default:    readdata = 32'd0;
            endcase
        end
    end

    assign led = led_q;
    assign irq = match_q && ctrl_q[2];

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: stimulus queues expected values, a monitor
// process pops and compares them against the DUT outputs.
module tb_dmem_mmio_responder;

    localparam logic [31:0] ALed     = 32'hFFFF_0000;
    localparam logic [31:0] ASw      = 32'hFFFF_0004;
    localparam logic [31:0] ACount   = 32'hFFFF_0008;
    localparam logic [31:0] ACompare = 32'hFFFF_000C;
    localparam logic [31:0] ACtrl    = 32'hFFFF_0010;
    localparam logic [31:0] AStatus  = 32'hFFFF_0014;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [15:0] sw = 16'd0;
    logic [15:0] led;
    logic        irq;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   n_cmp = 0;
    int   n_err = 0;

    dmem_mmio_responder #(
        .RAM_AW   (10),
        .MMIO_BASE(32'hFFFF_0000),
        .PRESCALE (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MemWrite (MemWrite),
        .addr     (addr),
        .writedata(writedata),
        .readdata (readdata),
        .sw       (sw),
        .led      (led),
        .irq      (irq)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: drains the scoreboard each time the stimulus signals a sample point.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.sel)
                    0:       act = readdata;
                    1:       act = {16'd0, led};
                    default: act = {31'd0, irq};
                endcase
                n_cmp++;
                if (act !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got %08h expected %08h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic chk(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = v;
        sb_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] v);
        addr = a;
        #1;
        chk(name, 0, v);
    endtask

    // Called at a falling edge; commits on the next rising edge, returns at the next fall.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1;
        chk("rst_led", 1, 32'd0);
        chk("rst_irq", 2, 32'd0);
        rd_chk("rst_led_reg", ALed, 32'd0);
        rd_chk("rst_count", ACount, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // RAM store/load
        wr(32'h0000_0000, 32'hCAFE_0000);
        wr(32'h0000_0010, 32'h1111_1111);
        addr      = 32'h0000_0010;
        writedata = 32'hDEAD_BEEF;
        MemWrite  = 1'b1;
        #1;
        chk("ram_rdw_old", 0, 32'h1111_1111);
        @(negedge clk);
        MemWrite = 1'b0;
        rd_chk("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_load_b3", 32'h0000_0013, 32'hDEAD_BEEF);

        // LED and unmapped
        wr(ALed, 32'h1234_ABCD);
        chk("led_out", 1, 32'h0000_ABCD);
        rd_chk("led_read", ALed, 32'h0000_ABCD);
        wr(32'h8000_0000, 32'h5555_5555);
        wr(32'h8000_0010, 32'h7777_7777);
        wr(32'hFFFF_0020, 32'h9999_9999);
        rd_chk("unmapped_rd", 32'h8000_0000, 32'd0);
        rd_chk("ram_untouched10", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_untouched0", 32'h0000_0000, 32'hCAFE_0000);
        @(negedge clk);
        rd_chk("mmio_hole_rd", 32'hFFFF_0020, 32'd0);

        // Switch synchroniser
        @(negedge clk);
        sw = 16'h00F0;
        rd_chk("sw_0edge", ASw, 32'd0);
        wait_n(1);
        rd_chk("sw_1edge", ASw, 32'd0);
        wait_n(1);
        rd_chk("sw_2edge", ASw, 32'h0000_00F0);
        wr(ASw, 32'h0000_FFFF);
        rd_chk("sw_ro", ASw, 32'h0000_00F0);

        // Timer, auto-reload; CTRL write commits at E0, ticks at E4, E8, ...
        @(negedge clk);
        wr(ACompare, 32'd3);
        wr(ACtrl, 32'h0000_0007);
        rd_chk("cnt_n1", ACount, 32'd0);
        wait_n(3);
        rd_chk("cnt_n4", ACount, 32'd0);
        wait_n(1);
        rd_chk("cnt_n5", ACount, 32'd1);
        wait_n(4);
        rd_chk("cnt_n9", ACount, 32'd2);
        wait_n(4);
        rd_chk("cnt_n13", ACount, 32'd3);
        rd_chk("stat_n13", AStatus, 32'd0);
        chk("irq_n13", 2, 32'd0);
        wait_n(3);
        rd_chk("cnt_n16", ACount, 32'd3);
        wait_n(1);
        rd_chk("cnt_reload", ACount, 32'd0);
        rd_chk("stat_match", AStatus, 32'd1);
        chk("irq_match", 2, 32'd1);
        wr(AStatus, 32'd1);
        rd_chk("stat_w1c", AStatus, 32'd0);
        chk("irq_w1c", 2, 32'd0);

        // W1C in the same cycle as the match tick at E32
        wait_n(14);
        wr(AStatus, 32'd1);
        rd_chk("stat_set_wins", AStatus, 32'd1);
        chk("irq_set_wins", 2, 32'd1);
        rd_chk("cnt_n33", ACount, 32'd0);
        wr(AStatus, 32'd0);
        rd_chk("stat_w0_noop", AStatus, 32'd1);
        wr(AStatus, 32'd1);

        // COUNT write in the tick cycle at E36
        wait_n(1);
        wr(ACount, 32'h0000_0100);
        rd_chk("cnt_cpu_wins", ACount, 32'h0000_0100);
        wait_n(3);
        rd_chk("cnt_n40", ACount, 32'h0000_0100);
        wait_n(1);
        rd_chk("cnt_n41", ACount, 32'h0000_0101);

        // Wrap with no match, then match without reload
        wr(ACompare, 32'd0);
        wr(ACtrl, 32'hFFFF_FFFD);
        rd_chk("ctrl_mask", ACtrl, 32'h0000_0005);
        wr(ACount, 32'hFFFF_FFFF);
        rd_chk("cnt_n44", ACount, 32'hFFFF_FFFF);
        wait_n(1);
        rd_chk("cnt_wrap", ACount, 32'd0);
        rd_chk("stat_wrap", AStatus, 32'd0);
        wait_n(4);
        rd_chk("cnt_noreload", ACount, 32'd1);
        rd_chk("stat_n49", AStatus, 32'd1);
        chk("irq_n49", 2, 32'd1);

        // Asynchronous reset pulse mid-run
        wait_n(1);
        rst = 1'b0;
        #1;
        chk("arst_irq", 2, 32'd0);
        chk("arst_led", 1, 32'd0);
        rd_chk("arst_count", ACount, 32'd0);
        rd_chk("arst_status", AStatus, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rd_chk("arst_ram10", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("arst_ram0", 32'h0000_0000, 32'hCAFE_0000);
        rd_chk("arst_ctrl", ACtrl, 32'd0);

        #2;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
